// File: rtl/regfile_write_arbiter.sv
// Module: regfile_write_arbiter
// Shares the register file's single write port between pipeline writeback (WB)
// and the multi-cycle unit (MC). WB normally wins. After MC has lost
// STARVE_LIMIT consecutive cycles the FSM enters FORCE and MC wins once.
// Writes reach the register file one registered cycle after acceptance.
// Optional feature: define REGFILE_ARB_STATS_EN to add the conflict_cnt_o and
// force_cnt_o saturating statistics counters.
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid_i,
    input  logic [4:0]       wb_rd_i,
    input  logic [31:0]      wb_data_i,
    output logic             wb_ready_o,
    input  logic             mc_valid_i,
    input  logic [4:0]       mc_rd_i,
    input  logic [31:0]      mc_data_i,
    output logic             mc_ready_o,
    output logic             reg_file_writeen_o,
    output logic [4:0]       dest_reg_o,
    output logic [31:0]      wr_data_o,
`ifdef REGFILE_ARB_STATS_EN
    output logic [CNT_W-1:0] conflict_cnt_o,
    output logic [CNT_W-1:0] force_cnt_o,
`endif
    output logic             mc_forced_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic {
        ST_NORMAL,
        ST_FORCE
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic          wb_nz, mc_nz;
    logic          wb_grant, mc_grant;

    // Pick the single nonzero-destination winner; x0 requests are simply absorbed
    always_comb begin
        wb_nz    = wb_valid_i && (wb_rd_i != 5'd0);
        mc_nz    = mc_valid_i && (mc_rd_i != 5'd0);
        wb_grant = 1'b0;
        mc_grant = 1'b0;
        if (state == ST_FORCE) begin
            mc_grant = mc_nz;
            wb_grant = wb_nz && !mc_nz;
        end else begin
            wb_grant = wb_nz;
            mc_grant = mc_nz && !wb_nz;
        end
        wb_ready_o  = reset && ((wb_rd_i == 5'd0) || wb_grant);
        mc_ready_o  = reset && ((mc_rd_i == 5'd0) || mc_grant);
        mc_forced_o = (state == ST_FORCE);
    end

    // Starvation count and FSM transition; FORCE is entered as soon as the count reaches the limit
    always_comb begin
        starve_nxt = starve_cnt;
        state_nxt  = state;
        if (!mc_valid_i || mc_grant) begin
            starve_nxt = '0;
        end else if (mc_nz && (starve_cnt != LIMIT)) begin
            starve_nxt = starve_cnt + 1'b1;
        end
        case (state)
            ST_NORMAL: if (starve_nxt == LIMIT) state_nxt = ST_FORCE;
            ST_FORCE:  if (mc_grant || !mc_valid_i) state_nxt = ST_NORMAL;
            default:   state_nxt = ST_NORMAL;
        endcase
    end

    // FSM state and starvation counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Registered write port; address and data hold their last values when idle
    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_file_writeen_o <= 1'b0;
            dest_reg_o         <= 5'd0;
            wr_data_o          <= 32'd0;
        end else begin
            reg_file_writeen_o <= wb_grant || mc_grant;
            if (mc_grant) begin
                dest_reg_o <= mc_rd_i;
                wr_data_o  <= mc_data_i;
            end else if (wb_grant) begin
                dest_reg_o <= wb_rd_i;
                wr_data_o  <= wb_data_i;
            end
        end
    end

`ifdef REGFILE_ARB_STATS_EN
    // Saturating statistics: contested cycles and forced MC grants
    always_ff @(posedge clk) begin
        if (!reset) begin
            conflict_cnt_o <= '0;
            force_cnt_o    <= '0;
        end else begin
            if (wb_nz && mc_nz && (conflict_cnt_o != '1))
                conflict_cnt_o <= conflict_cnt_o + 1'b1;
            if ((state == ST_FORCE) && mc_grant && (force_cnt_o != '1))
                force_cnt_o <= force_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter with STARVE_LIMIT=2.
// Directed vectors with hand-computed expectations; stats checks only when
// REGFILE_ARB_STATS_EN is defined.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        wb_ready_o;
    logic        mc_valid_i;
    logic [4:0]  mc_rd_i;
    logic [31:0] mc_data_i;
    logic        mc_ready_o;
    logic        reg_file_writeen_o;
    logic [4:0]  dest_reg_o;
    logic [31:0] wr_data_o;
    logic        mc_forced_o;
`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] conflict_cnt_o;
    logic [15:0] force_cnt_o;
`endif

    int checkCount = 0;
    int errorCount = 0;

    regfile_write_arbiter #(.STARVE_LIMIT(2), .CNT_W(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .wb_valid_i         (wb_valid_i),
        .wb_rd_i            (wb_rd_i),
        .wb_data_i          (wb_data_i),
        .wb_ready_o         (wb_ready_o),
        .mc_valid_i         (mc_valid_i),
        .mc_rd_i            (mc_rd_i),
        .mc_data_i          (mc_data_i),
        .mc_ready_o         (mc_ready_o),
        .reg_file_writeen_o (reg_file_writeen_o),
        .dest_reg_o         (dest_reg_o),
        .wr_data_o          (wr_data_o),
`ifdef REGFILE_ARB_STATS_EN
        .conflict_cnt_o     (conflict_cnt_o),
        .force_cnt_o        (force_cnt_o),
`endif
        .mc_forced_o        (mc_forced_o)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic wv, input logic [4:0] wrd, input logic [31:0] wdata,
                                 input logic mv, input logic [4:0] mrd, input logic [31:0] mdata);
        reset      = rst;
        wb_valid_i = wv;
        wb_rd_i    = wrd;
        wb_data_i  = wdata;
        mc_valid_i = mv;
        mc_rd_i    = mrd;
        mc_data_i  = mdata;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // One contested cycle: check comb readies before the edge, then the registered write
    task automatic contestCycle(input string tag, input logic expWb, input logic expMc,
                                input logic expForced, input logic [4:0] expDest);
        #2;
        checkOutput({tag, "_wb_ready"}, 32'(wb_ready_o), 32'(expWb));
        checkOutput({tag, "_mc_ready"}, 32'(mc_ready_o), 32'(expMc));
        checkOutput({tag, "_forced"}, 32'(mc_forced_o), 32'(expForced));
        stepCycle();
        checkOutput({tag, "_wen"}, 32'(reg_file_writeen_o), 32'd1);
        checkOutput({tag, "_dest"}, 32'(dest_reg_o), 32'(expDest));
    endtask

    initial begin
        // Reset with a request pending: readies held low, outputs cleared
        applyStimulus(1'b0, 1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd6, 32'h2222_2222);
        stepCycle();
        stepCycle();
        checkOutput("rst_wb_ready", 32'(wb_ready_o), 32'd0);
        checkOutput("rst_mc_ready", 32'(mc_ready_o), 32'd0);
        checkOutput("rst_wen", 32'(reg_file_writeen_o), 32'd0);
        checkOutput("rst_dest", 32'(dest_reg_o), 32'd0);
        checkOutput("rst_data", wr_data_o, 32'd0);
        checkOutput("rst_forced", 32'(mc_forced_o), 32'd0);

        // WB alone: accepted same cycle, written next cycle, then held
        applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        #2;
        checkOutput("wb_only_ready", 32'(wb_ready_o), 32'd1);
        stepCycle();
        checkOutput("wb_only_wen", 32'(reg_file_writeen_o), 32'd1);
        checkOutput("wb_only_dest", 32'(dest_reg_o), 32'd5);
        checkOutput("wb_only_data", wr_data_o, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        stepCycle();
        checkOutput("idle_wen", 32'(reg_file_writeen_o), 32'd0);
        checkOutput("idle_dest_hold", 32'(dest_reg_o), 32'd5);
        checkOutput("idle_data_hold", wr_data_o, 32'hDEAD_BEEF);

        // Starvation: WB x3 continuous, MC x7 waiting -> WB, WB, MC forced, WB
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd7, 32'h0000_0077);
        contestCycle("starve0", 1'b1, 1'b0, 1'b0, 5'd3);
        contestCycle("starve1", 1'b1, 1'b0, 1'b0, 5'd3);
        contestCycle("starve2", 1'b0, 1'b1, 1'b1, 5'd7);
        checkOutput("starve2_data", wr_data_o, 32'h0000_0077);
        contestCycle("starve3", 1'b1, 1'b0, 1'b0, 5'd3);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        stepCycle();

        // WB to x0 with MC to x9: both accepted, only x9 written
        applyStimulus(1'b1, 1'b1, 5'd0, 32'hAAAA_AAAA, 1'b1, 5'd9, 32'h0000_0099);
        #2;
        checkOutput("x0_wb_ready", 32'(wb_ready_o), 32'd1);
        checkOutput("x0_mc_ready", 32'(mc_ready_o), 32'd1);
        stepCycle();
        checkOutput("x0_wen", 32'(reg_file_writeen_o), 32'd1);
        checkOutput("x0_dest", 32'(dest_reg_o), 32'd9);
        checkOutput("x0_data", wr_data_o, 32'h0000_0099);
        applyStimulus(1'b1, 1'b1, 5'd0, 32'hAAAA_AAAA, 1'b0, 5'd0, 32'd0);
        stepCycle();
        checkOutput("x0_only_wen", 32'(reg_file_writeen_o), 32'd0);
        checkOutput("x0_only_dest", 32'(dest_reg_o), 32'd9);

        // Reset while in FORCE with MC pending
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd7, 32'h0000_0077);
        stepCycle();
        stepCycle();
        #2;
        checkOutput("frst_in_force", 32'(mc_forced_o), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("frst_wb_ready", 32'(wb_ready_o), 32'd0);
        checkOutput("frst_mc_ready", 32'(mc_ready_o), 32'd0);
        stepCycle();
        checkOutput("frst_wen", 32'(reg_file_writeen_o), 32'd0);
        checkOutput("frst_dest", 32'(dest_reg_o), 32'd0);
        checkOutput("frst_data", wr_data_o, 32'd0);
        checkOutput("frst_forced", 32'(mc_forced_o), 32'd0);
        reset = 1'b1;
        // Counter restarted from zero, so MC needs two more lost cycles
        contestCycle("post_rst0", 1'b1, 1'b0, 1'b0, 5'd3);
        contestCycle("post_rst1", 1'b1, 1'b0, 1'b0, 5'd3);
        contestCycle("post_rst2", 1'b0, 1'b1, 1'b1, 5'd7);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        stepCycle();

`ifdef REGFILE_ARB_STATS_EN
        // Three contested cycles: one of them is a forced MC grant
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        stepCycle();
        checkOutput("stats_rst_conflict", 32'(conflict_cnt_o), 32'd0);
        checkOutput("stats_rst_force", 32'(force_cnt_o), 32'd0);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd7, 32'h0000_0077);
        stepCycle();
        stepCycle();
        stepCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        stepCycle();
        checkOutput("stats_conflict", 32'(conflict_cnt_o), 32'd3);
        checkOutput("stats_force", 32'(force_cnt_o), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
